// File: rtl/rr_arbiter_4_pkg.sv
// rr_arb_pkg: shared constants, FSM state type and one-hot encode helper
// for the 4-way round-robin arbiter slice.
//   NUM_REQ        - number of requesters (fixed at 4)
//   IDX_W          - width of the encoded grant index
//   state_t        - arbiter FSM states (ST_IDLE, ST_GRANT)
//   onehot4_to_idx - 4-to-2 one-hot encoder
package rr_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Plain OR-tree encoder; only meaningful for one-hot or zero input.
    function automatic logic [IDX_W-1:0] onehot4_to_idx(input logic [NUM_REQ-1:0] g);
        return {g[3] | g[2], g[3] | g[1]};
    endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// rr_arbiter_4_if: request/grant bundle between requesters and the arbiter.
//   req[3:0]        - request vector, bit i = requester i
//   done            - current owner has finished
//   grant[3:0]      - one-hot grant (registered in the arbiter)
//   grant_idx[1:0]  - binary index of grant, 0 when idle
//   grant_valid     - any grant bit set
//   timeout         - one-cycle pulse after a forced release
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter_4_if;
    import rr_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               timeout;

    modport master (
        output req, done,
        input  grant, grant_idx, grant_valid, timeout
    );

    modport slave (
        input  req, done,
        output grant, grant_idx, grant_valid, timeout
    );

endinterface

// File: rtl/rr_arbiter_4_pick.sv
// rr_pick_4: combinational rotating-priority picker.
// Searches req starting at last_ptr+1 (mod 4) and returns the first set bit.
//   req[3:0]         - request vector
//   last_ptr[1:0]    - index of the most recently served requester
//   pick_onehot[3:0] - one-hot winner, zero if no request
//   pick_idx[1:0]    - binary winner index, zero if no request
//   pick_any         - any request present
module rr_pick_4
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_ptr,
    output logic [NUM_REQ-1:0] pick_onehot,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               pick_any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        pick_onehot = '0;
        cand        = '0;
        // Offsets 1..4 visit every requester once; IDX_W-bit add wraps mod 4,
        // so offset 4 lands back on last_ptr itself as lowest priority.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = last_ptr + IDX_W'(k);
            if (pick_onehot == '0 && req[cand]) begin
                pick_onehot[cand] = 1'b1;
            end
        end
    end

    assign pick_idx = onehot4_to_idx(pick_onehot);
    assign pick_any = |req;

endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: round-robin arbiter sharing one resource among 4 requesters.
// Grants are registered, held until done, request drop, or hold timeout.
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus    - rr_arbiter_4_if.slave: req, done in; grant, grant_idx,
//            grant_valid, timeout out (all outputs registered)
// Parameter MAX_HOLD: cycles a grant may be held; 0 disables the timeout.
module rr_arbiter_4
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter_4_if.slave bus
);

    localparam int unsigned      HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0]   HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam bit               TO_EN     = (MAX_HOLD != 0);

    state_t             state_q, state_d;
    logic [HCW-1:0]     hold_q, hold_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               to_q, to_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               rel_user;
    logic               rel_time;

    rr_pick_4 u_pick (
        .req         (bus.req),
        .last_ptr    (last_q),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_any    (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        last_d   = last_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        to_d     = 1'b0;
        rel_user = 1'b0;
        rel_time = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_onehot;
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                    hold_d  = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Owner release (done / request drop) outranks the timeout,
                // so timeout only pulses when it was the sole cause.
                rel_user = bus.done || !bus.req[idx_q];
                rel_time = TO_EN && (hold_q == HOLD_LAST);
                if (rel_user || rel_time) begin
                    grant_d = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    last_d  = idx_q;
                    to_d    = !rel_user;
                    state_d = ST_IDLE;
                end else if (hold_q != '1) begin
                    // Saturate rather than wrap; only reachable with MAX_HOLD=0.
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            last_q  <= 2'd3;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            to_q    <= to_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
    assign bus.timeout     = to_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4: directed and randomized checks of rr_arbiter_4 (MAX_HOLD=4)
// against a cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter_4;
    import rr_arb_pkg::*;

    localparam int unsigned MH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rr_arbiter_4_if bus_i();

    rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: owner = -1 when idle; held = number of cycles grant has been visible.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 3;
    bit m_to    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_step();
        bit by_user;
        bit by_time;
        int c;
        if (!rst_n) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = 3;
            m_to    = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                c = (m_last + k) % 4;
                if (m_owner < 0 && bus_i.req[c] === 1'b1) begin
                    m_owner = c;
                    m_held  = 1;
                end
            end
        end else begin
            by_user = bus_i.done || !bus_i.req[m_owner];
            by_time = (MH != 0) && (m_held == int'(MH));
            if (by_user || by_time) begin
                m_last  = m_owner;
                m_owner = -1;
                m_held  = 0;
                m_to    = !by_user;
            end else begin
                m_held++;
                m_to = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] eg;
        logic [1:0] ei;
        eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        ei = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        chk("grant",       32'(bus_i.grant),       32'(eg));
        chk("grant_idx",   32'(bus_i.grant_idx),   32'(ei));
        chk("grant_valid", 32'(bus_i.grant_valid), 32'(m_owner >= 0));
        chk("timeout",     32'(bus_i.timeout),     32'(m_to));
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare.
    task automatic cyc(input logic [3:0] r, input logic d, input logic rn);
        bus_i.req  = r;
        bus_i.done = d;
        rst_n      = rn;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] seq [5];
        bus_i.req  = '0;
        bus_i.done = 1'b0;

        // Reset with all requesting, then first grant goes to requester 0.
        cyc(4'b1111, 1'b0, 1'b0);
        cyc(4'b1111, 1'b0, 1'b0);
        chk("rst_grant", 32'(bus_i.grant), 32'h0);
        cyc(4'b1111, 1'b0, 1'b1);
        chk("first_grant", 32'(bus_i.grant), 32'b0001);
        cyc(4'b1111, 1'b1, 1'b1);

        // Single requester with done three cycles after grant.
        cyc(4'b0100, 1'b0, 1'b1);
        chk("single_grant", 32'(bus_i.grant), 32'b0100);
        chk("single_idx", 32'(bus_i.grant_idx), 32'd2);
        cyc(4'b0100, 1'b0, 1'b1);
        cyc(4'b0100, 1'b0, 1'b1);
        cyc(4'b0100, 1'b1, 1'b1);
        chk("single_drop", 32'(bus_i.grant), 32'h0);
        chk("single_noto", 32'(bus_i.timeout), 32'h0);

        // Fairness sweep from reset pointer.
        cyc(4'b0000, 1'b0, 1'b0);
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
        seq[3] = 4'b1000; seq[4] = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            cyc(4'b1111, 1'b0, 1'b1);
            chk("rr_grant", 32'(bus_i.grant), 32'(seq[i]));
            cyc(4'b1111, 1'b1, 1'b1);
            chk("rr_idle", 32'(bus_i.grant_valid), 32'h0);
        end

        // Wrap: after serving 2, requester 0 precedes 1.
        cyc(4'b0100, 1'b0, 1'b1);
        cyc(4'b0100, 1'b1, 1'b1);
        cyc(4'b0011, 1'b0, 1'b1);
        chk("wrap_first", 32'(bus_i.grant), 32'b0001);
        cyc(4'b0011, 1'b1, 1'b1);
        cyc(4'b0011, 1'b0, 1'b1);
        chk("wrap_second", 32'(bus_i.grant), 32'b0010);
        cyc(4'b0011, 1'b1, 1'b1);

        // Timeout: grant visible exactly MH cycles, then pulse, then re-grant.
        for (int i = 0; i < int'(MH); i++) begin
            cyc(4'b0010, 1'b0, 1'b1);
            chk("to_hold", 32'(bus_i.grant), 32'b0010);
        end
        cyc(4'b0010, 1'b0, 1'b1);
        chk("to_pulse", 32'(bus_i.timeout), 32'h1);
        chk("to_grant0", 32'(bus_i.grant), 32'h0);
        cyc(4'b0010, 1'b0, 1'b1);
        chk("to_regrant", 32'(bus_i.grant), 32'b0010);
        chk("to_clear", 32'(bus_i.timeout), 32'h0);
        cyc(4'b0010, 1'b0, 1'b1);
        cyc(4'b0010, 1'b0, 1'b1);
        cyc(4'b0010, 1'b0, 1'b1);
        cyc(4'b0010, 1'b1, 1'b1);
        chk("to_done_wins", 32'(bus_i.timeout), 32'h0);
        chk("to_done_drop", 32'(bus_i.grant), 32'h0);

        // Reset while requester 3 holds the grant.
        cyc(4'b1000, 1'b0, 1'b1);
        chk("mid_grant", 32'(bus_i.grant), 32'b1000);
        cyc(4'b1111, 1'b0, 1'b0);
        chk("mid_rst", 32'(bus_i.grant), 32'h0);
        cyc(4'b1111, 1'b0, 1'b1);
        chk("mid_after", 32'(bus_i.grant), 32'b0001);

        // Randomized traffic; requests often held steady so timeouts occur.
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) r = 4'($urandom);
            if ($urandom_range(0, 7) == 0) r = 4'b0000;
            cyc(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 49) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
